// File: rtl/clock_pkg.sv
// Shared encodings for the clock mode/set controller: mode values and
// the per-field blink masks used by the display driver.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam logic [2:0] MASK_HOUR = 3'b100;
    localparam logic [2:0] MASK_MIN  = 3'b010;
    localparam logic [2:0] MASK_SEC  = 3'b001;
    localparam logic [2:0] MASK_NONE = 3'b000;

    function automatic logic [2:0] field_mask(input mode_e m);
        logic [2:0] r;
        r = MASK_NONE;
        case (m)
            MODE_SET_HOUR: r = MASK_HOUR;
            MODE_SET_MIN:  r = MASK_MIN;
            MODE_SET_SEC:  r = MASK_SEC;
            default:       r = MASK_NONE;
        endcase
        return r;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        r = MODE_RUN;
        case (m)
            MODE_RUN:      r = MODE_SET_HOUR;
            MODE_SET_HOUR: r = MODE_SET_MIN;
            MODE_SET_MIN:  r = MODE_SET_SEC;
            default:       r = MODE_RUN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key_repeat.sv
// Edge detect plus hold/auto-repeat timer for one debounced key. strobe is
// combinational (press or repeat) and is suppressed whenever cancel is high.
module key_repeat #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic rpt_en,
    input  logic cancel,
    output logic strobe,
    output logic holding
);
    import clock_pkg::*;

    localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic          key_q;
    logic          holding_q, holding_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press, fire;

    assign press   = key & ~key_q;
    assign fire    = holding_q & key & (cnt_q == '0);
    assign strobe  = (press | fire) & ~cancel;
    assign holding = holding_q;

    // Down-counter reaches zero on the cycle a repeat strobe is due; the
    // press cycle itself counts as the first held cycle.
    always_comb begin
        holding_d = holding_q;
        cnt_d     = cnt_q;
        if (cancel || !key) begin
            holding_d = 1'b0;
            cnt_d     = '0;
        end else if (press) begin
            holding_d = rpt_en;
            cnt_d     = rpt_en ? CW'(HOLD_CYCLES - 2) : '0;
        end else if (fire) begin
            cnt_d = CW'(REPEAT_CYCLES - 1);
        end else if (holding_q && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= 1'b0;
            holding_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            key_q     <= key;
            holding_q <= holding_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller: 1 Hz prescaler, RUN/SET mode FSM, adjust
// strobes with auto-repeat on the increment key, and field blink mask.
module clock_set_ctrl #(
    parameter int TICK_DIV      = 50000000,
    parameter int BLINK_DIV     = 12500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       cnt_en,
    output logic       adj_min,
    output logic       adj_hour,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic [2:0] blink_mask
);
    import clock_pkg::*;

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    mode_e         state_q, state_d;
    logic          mode_key_q;
    logic          mode_press;
    logic          inc_strobe, inc_holding;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          cnt_en_d, adj_min_d, adj_hour_d, sec_clr_d;
    logic [2:0]    mask_d;
    logic          adj_act;

    assign mode_press = key_mode & ~mode_key_q;
    assign mode       = state_q;

    key_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_inc (
        .clk    (clk),
        .rst    (rst),
        .key    (key_inc),
        .rpt_en (state_q == MODE_SET_HOUR || state_q == MODE_SET_MIN),
        .cancel (mode_press),
        .strobe (inc_strobe),
        .holding(inc_holding)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MODE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            state_d = next_mode(state_q);
        end
    end

    always_comb begin
        presc_d     = '0;
        cnt_en_d    = 1'b0;
        adj_min_d   = 1'b0;
        adj_hour_d  = 1'b0;
        sec_clr_d   = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        adj_act     = inc_strobe && (state_q != MODE_RUN);

        // Prescaler only advances while staying in RUN, so leaving RUN on a
        // tick cycle never produces a tick alongside a SET mode value.
        if (state_q == MODE_RUN && state_d == MODE_RUN) begin
            if (presc_q == TICK_LAST) begin
                cnt_en_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        case (state_q)
            MODE_SET_HOUR: adj_hour_d = inc_strobe;
            MODE_SET_MIN:  adj_min_d  = inc_strobe;
            MODE_SET_SEC:  sec_clr_d  = inc_strobe;
            default:       ;
        endcase

        // Blink restarts from the visible phase in RUN, on SET entry and
        // while the operator is adjusting.
        if (state_d == MODE_RUN || state_q == MODE_RUN || adj_act || inc_holding) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        mask_d = field_mask(state_d) & {3{phase_d}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_key_q  <= 1'b0;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            cnt_en      <= 1'b0;
            adj_min     <= 1'b0;
            adj_hour    <= 1'b0;
            sec_clr     <= 1'b0;
            blink_mask  <= 3'b000;
        end else begin
            mode_key_q  <= key_mode;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            cnt_en      <= cnt_en_d;
            adj_min     <= adj_min_d;
            adj_hour    <= adj_hour_d;
            sec_clr     <= sec_clr_d;
            blink_mask  <= mask_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios then random key activity,
// every cycle compared against a timestamp-based reference model.
module tb_clock_set_ctrl;

    localparam int TICK   = 4;
    localparam int BLINK  = 2;
    localparam int HOLD   = 8;
    localparam int REP    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       cnt_en, adj_min, adj_hour, sec_clr;
    logic [1:0] mode;
    logic [2:0] blink_mask;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];

    // reference model state: timestamps in posedge counts
    int t = 0;
    int pm = 0, pi = 0;
    int mode_m = 0;
    int run_start = 0;
    int holding = 0;
    int p = 0;
    int anchor = 0;

    clock_set_ctrl #(
        .TICK_DIV     (TICK),
        .BLINK_DIV    (BLINK),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .cnt_en    (cnt_en),
        .adj_min   (adj_min),
        .adj_hour  (adj_hour),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got={en,min,hr,clr,mode,mask}=%b_%b_%b_%b_%0d_%b exp=%b_%b_%b_%b_%0d_%b",
                     tag, t, got[8], got[7], got[6], got[5], got[4:3], got[2:0],
                     exp[8], exp[7], exp[6], exp[5], exp[4:3], exp[2:0]);
        end
    endtask

    task automatic model_edge(input int km, input int ki, input int r);
        int mp, ip, old, was_h, strobe, en, ph, d;
        logic [2:0] fmask;
        t++;
        if (r != 0) begin
            pm = 0; pi = 0; mode_m = 0; run_start = t; holding = 0; anchor = t;
            exp_q.push_back(9'd0);
            return;
        end
        mp = (km != 0 && pm == 0) ? 1 : 0;
        ip = (ki != 0 && pi == 0) ? 1 : 0;
        pm = km; pi = ki;
        old = mode_m; was_h = holding; strobe = 0;
        if (mp != 0) begin
            mode_m = (old + 1) % 4;
            holding = 0;
        end else begin
            d = t - p;
            if (ip != 0 && old != 0) strobe = 1;
            else if (holding != 0 && ki != 0 &&
                     (d == HOLD - 1 || (d > HOLD - 1 && (d - (HOLD - 1)) % REP == 0))) strobe = 1;
            if (ki == 0) holding = 0;
            else if (ip != 0 && (old == 1 || old == 2)) begin
                holding = 1;
                p = t;
            end
        end
        en = (old == 0 && mode_m == 0 && (t - run_start) % TICK == 0) ? 1 : 0;
        if (mode_m == 0 && old != 0) run_start = t;
        if (mode_m == 0 || old == 0 || strobe != 0 || was_h != 0) anchor = t;
        ph = ((t - anchor) / BLINK) % 2;
        fmask = (mode_m == 1) ? 3'b100 : (mode_m == 2) ? 3'b010 : (mode_m == 3) ? 3'b001 : 3'b000;
        if (ph == 0) fmask = 3'b000;
        exp_q.push_back({en[0], (strobe != 0 && old == 2), (strobe != 0 && old == 1),
                         (strobe != 0 && old == 3), 2'(mode_m), fmask});
    endtask

    task automatic cycle(input int km, input int ki, input int r);
        logic [8:0] e;
        key_mode = (km != 0);
        key_inc  = (ki != 0);
        rst      = (r != 0);
        @(posedge clk);
        model_edge(km, ki, r);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 9'h1ff, 9'h000);
        end else begin
            e = exp_q.pop_front();
            check(r != 0 ? "reset" : "outs",
                  {cnt_en, adj_min, adj_hour, sec_clr, mode, blink_mask}, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic press_mode();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
    endtask

    task automatic hold_inc(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0);
    endtask

    initial begin
        int km, ki;
        ki = 0;
        // reset, then idle ticks
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        idle(12);
        // four mode presses 5 cycles apart, then back in RUN
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            idle(4);
        end
        idle(6);
        // single inc press in each SET mode
        for (int m = 0; m < 3; m++) begin
            press_mode();
            idle(2);
            cycle(0, 1, 0);
            idle(3);
        end
        press_mode();
        idle(3);
        // long holds in SET_MIN and SET_SEC
        press_mode(); press_mode();
        hold_inc(20);
        idle(5);
        press_mode();
        hold_inc(20);
        idle(3);
        press_mode();
        idle(2);
        // simultaneous mode+inc, then reset mid-repeat
        press_mode();
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        idle(2);
        hold_inc(12);
        #2 rst = 1'b1;
        #1 check("rst_async", {cnt_en, adj_min, adj_hour, sec_clr, mode, blink_mask}, 9'd0);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        idle(6);
        // blink in SET_MIN, then with a repeat in progress
        press_mode(); press_mode();
        idle(10);
        hold_inc(15);
        idle(6);
        // random key activity
        for (int i = 0; i < 3000; i++) begin
            km = ($urandom_range(0, 9) == 0) ? 1 : 0;
            if (ki != 0) ki = ($urandom_range(0, 11) == 0) ? 0 : 1;
            else ki = ($urandom_range(0, 5) == 0) ? 1 : 0;
            cycle(km, ki, ($urandom_range(0, 499) == 0) ? 1 : 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
